// File: rtl/pulse_seq.sv
// rtl/pulse_seq.sv - spin-echo pulse-train sequencer with double-buffered timing
module pulse_seq #(
  parameter int CW = 32,
  parameter int TW = 16,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] per,
  input  logic [TW-1:0] p1wid,
  input  logic [TW-1:0] del,
  input  logic [TW-1:0] p2wid,
  input  logic [NW-1:0] npi,
  input  logic          pump,
  input  logic          blk_en,
  input  logic [TW-1:0] blk_pre,
  input  logic [TW-1:0] blk_win,
  input  logic          nut_en,
  input  logic [TW-1:0] nut_w,
  input  logic [TW-1:0] nut_d,
  output logic          sync,
  output logic          pulse,
  output logic          inhib,
  output logic          frame,
  output logic          load_ack
);

  typedef struct packed {
    logic [CW-1:0] per;
    logic [TW-1:0] p1wid;
    logic [TW-1:0] del;
    logic [TW-1:0] p2wid;
    logic [NW-1:0] npi;
    logic          pump;
    logic          blk_en;
    logic [TW-1:0] blk_pre;
    logic [TW-1:0] blk_win;
    logic          nut_en;
    logic [TW-1:0] nut_w;
    logic [TW-1:0] nut_d;
  } prm_t;

  typedef enum logic [2:0] {ST_IDLE, ST_CW, ST_FIRST, ST_TRAIN, ST_TAIL} state_t;

  // Block window start: e - pre, clamped at 0 when the window would open before t = 0.
  function automatic logic [CW-1:0] f_win_lo(input logic [CW-1:0] e, input logic [CW-1:0] pre);
    f_win_lo = (e >= pre) ? e - pre : '0;
  endfunction

  // Block window end (exclusive): e - pre + win, or 0 (empty) if it lies entirely before t = 0.
  function automatic logic [CW-1:0] f_win_hi(input logic [CW-1:0] e, input logic [CW-1:0] pre,
                                             input logic [CW-1:0] win);
    logic [CW-1:0] sum;
    sum = e + win;
    f_win_hi = (sum > pre) ? sum - pre : '0;
  endfunction

  prm_t          w_in, w_def, w_sel;
  prm_t          r_act, r_stg;
  logic          r_pend;
  state_t        r_state;
  logic [CW-1:0] r_t;
  logic [NW-1:0] r_k, r_bk;
  logic [CW-1:0] r_s, r_e, r_bs, r_be;
  logic          r_sync, r_pulse, r_inhib, r_frame, r_load_ack;

  logic [CW-1:0] w_p, w_t1, w_d, w_s_nx, w_e_nx;
  logic [CW-1:0] w_i_s, w_i_e;
  logic [CW-1:0] w_nsum, w_ns, w_ne;
  logic [CW-1:0] w_p1, w_p2;
  logic          w_wrap, w_cw, w_p1_on, w_pi_on, w_blk_on, w_nut_on;
  logic          w_pi_adv, w_blk_adv;
  logic          w_sync, w_pulse, w_inhib;

  // Gather the parameter pins into one bundle for staging / bypass.
  always_comb begin
    w_in.per     = per;
    w_in.p1wid   = p1wid;
    w_in.del     = del;
    w_in.p2wid   = p2wid;
    w_in.npi     = npi;
    w_in.pump    = pump;
    w_in.blk_en  = blk_en;
    w_in.blk_pre = blk_pre;
    w_in.blk_win = blk_win;
    w_in.nut_en  = nut_en;
    w_in.nut_w   = nut_w;
    w_in.nut_d   = nut_d;
  end

  // Power-up timing set: a single Hahn echo in a 65536-cycle period.
  always_comb begin
    w_def.per     = CW'(65536);
    w_def.p1wid   = TW'(30);
    w_def.del     = TW'(200);
    w_def.p2wid   = TW'(30);
    w_def.npi     = NW'(1);
    w_def.pump    = 1'b1;
    w_def.blk_en  = 1'b1;
    w_def.blk_pre = TW'(50);
    w_def.blk_win = TW'(100);
    w_def.nut_en  = 1'b0;
    w_def.nut_w   = '0;
    w_def.nut_d   = '0;
  end

  assign w_p    = (r_act.per < CW'(2)) ? CW'(2) : r_act.per;
  assign w_t1   = r_t + CW'(1);
  assign w_wrap = (w_t1 == w_p);

  // Set in force from the next t = 0: defaults on reset, pins on a wrap-cycle load,
  // staging if a load is pending, otherwise unchanged.
  always_comb begin
    w_sel = r_act;
    if (reset)                w_sel = w_def;
    else if (w_wrap && load)  w_sel = w_in;
    else if (w_wrap && r_pend) w_sel = r_stg;
  end

  // First pi pulse start and first echo centre for the set taking effect.
  assign w_i_s = CW'(w_sel.p1wid) + CW'(w_sel.del);
  assign w_i_e = w_i_s + CW'(w_sel.p2wid) + CW'(w_sel.del);

  // Spacing between consecutive pi pulses / echoes: 2*tau + pi width.
  assign w_p1   = CW'(r_act.p1wid);
  assign w_p2   = CW'(r_act.p2wid);
  assign w_d    = CW'(r_act.del) + CW'(r_act.del) + w_p2;
  assign w_s_nx = r_s + w_d;
  assign w_e_nx = r_e + w_d;

  // Nutation window anchored to the period end; both edges clamp at 0.
  assign w_nsum = CW'(r_act.nut_d) + CW'(r_act.nut_w);
  assign w_ns   = (w_nsum >= w_p) ? '0 : w_p - w_nsum;
  assign w_ne   = (CW'(r_act.nut_d) >= w_p) ? '0 : w_p - CW'(r_act.nut_d);

  assign w_cw     = (r_act.npi == '0);
  assign w_p1_on  = (r_t < w_p1);
  assign w_pi_on  = (r_k < r_act.npi) && (r_t >= r_s) && (r_t < r_s + w_p2);
  assign w_blk_on = (r_bk < r_act.npi) && (r_t >= r_bs) && (r_t < r_be);
  assign w_nut_on = r_act.nut_en && (r_t >= w_ns) && (r_t < w_ne);
  assign w_pi_adv  = (r_k < r_act.npi) && (w_t1 >= r_s + w_p2);
  assign w_blk_adv = (r_bk < r_act.npi) && (w_t1 >= r_be);

  // sync stays high until the last pi pulse has ended, i.e. while pi pulses remain.
  assign w_sync  = w_cw ? w_p1_on : (r_k < r_act.npi);
  assign w_pulse = w_cw ? 1'b1 : ((r_act.pump && w_p1_on) || w_pi_on || w_nut_on);
  assign w_inhib = w_cw ? 1'b0 : (r_act.blk_en && !w_blk_on);

  // Period counter, parameter banks, per-k event pointers, phase FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_t        <= '0;
      r_state    <= ST_IDLE;
      r_act      <= w_def;
      r_stg      <= w_def;
      r_pend     <= 1'b0;
      r_k        <= '0;
      r_bk       <= '0;
      r_s        <= w_i_s;
      r_e        <= w_i_e;
      r_bs       <= f_win_lo(w_i_e, CW'(w_sel.blk_pre));
      r_be       <= f_win_hi(w_i_e, CW'(w_sel.blk_pre), CW'(w_sel.blk_win));
      r_sync     <= 1'b0;
      r_pulse    <= 1'b0;
      r_inhib    <= 1'b0;
      r_frame    <= 1'b0;
      r_load_ack <= 1'b0;
    end else begin
      r_sync     <= w_sync;
      r_pulse    <= w_pulse;
      r_inhib    <= w_inhib;
      r_frame    <= (r_t == '0);
      r_load_ack <= w_wrap && (load || r_pend);
      if (w_wrap) begin
        r_t     <= '0;
        r_act   <= w_sel;
        r_pend  <= 1'b0;
        if (load) r_stg <= w_in;
        r_k     <= '0;
        r_bk    <= '0;
        r_s     <= w_i_s;
        r_e     <= w_i_e;
        r_bs    <= f_win_lo(w_i_e, CW'(w_sel.blk_pre));
        r_be    <= f_win_hi(w_i_e, CW'(w_sel.blk_pre), CW'(w_sel.blk_win));
        r_state <= (w_sel.npi == '0) ? ST_CW : ST_FIRST;
      end else begin
        r_t <= w_t1;
        if (load) begin
          r_stg  <= w_in;
          r_pend <= 1'b1;
        end
        if (w_pi_adv) begin
          r_k <= r_k + NW'(1);
          r_s <= w_s_nx;
        end
        if (w_blk_adv) begin
          r_bk <= r_bk + NW'(1);
          r_e  <= w_e_nx;
          r_bs <= f_win_lo(w_e_nx, CW'(r_act.blk_pre));
          r_be <= f_win_hi(w_e_nx, CW'(r_act.blk_pre), CW'(r_act.blk_win));
        end
        case (r_state)
          ST_IDLE, ST_FIRST: begin
            if (w_cw)              r_state <= ST_CW;
            else if (w_t1 >= w_p1) r_state <= ST_TRAIN;
            else                   r_state <= ST_FIRST;
          end
          ST_TRAIN: begin
            if (w_pi_adv && (r_k + NW'(1) == r_act.npi)) r_state <= ST_TAIL;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign sync     = r_sync;
  assign pulse    = r_pulse;
  assign inhib    = r_inhib;
  assign frame    = r_frame;
  assign load_ack = r_load_ack;

endmodule

// File: tb/tb_pulse_seq.sv
// tb/tb_pulse_seq.sv - scoreboard bench for pulse_seq against an arithmetic timing model
module tb_pulse_seq;
  localparam int CW = 32;
  localparam int TW = 16;
  localparam int NW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, load;
  logic [CW-1:0] per;
  logic [TW-1:0] p1wid, del, p2wid, blk_pre, blk_win, nut_w, nut_d;
  logic [NW-1:0] npi;
  logic          pump, blk_en, nut_en;
  logic          sync, pulse, inhib, frame, load_ack;

  pulse_seq #(.CW(CW), .TW(TW), .NW(NW)) dut (
    .clk(clk), .reset(reset), .load(load), .per(per), .p1wid(p1wid), .del(del),
    .p2wid(p2wid), .npi(npi), .pump(pump), .blk_en(blk_en), .blk_pre(blk_pre),
    .blk_win(blk_win), .nut_en(nut_en), .nut_w(nut_w), .nut_d(nut_d),
    .sync(sync), .pulse(pulse), .inhib(inhib), .frame(frame), .load_ack(load_ack)
  );

  typedef struct {
    longint per, p1, dl, p2, n, pre, win, nw, nd;
    bit     pump, ben, nen;
  } prm_t;

  typedef struct {
    logic [4:0] v;
    longint     t;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  prm_t   dflt, m_act, m_stg;
  bit     m_pend;
  longint m_t;

  function automatic prm_t mk(longint per_v, longint p1, longint dl, longint p2, longint n,
                              bit pu, bit be, longint pre, longint win, bit ne,
                              longint nw, longint nd);
    prm_t p;
    p.per = per_v; p.p1 = p1; p.dl = dl; p.p2 = p2; p.n = n; p.pump = pu; p.ben = be;
    p.pre = pre; p.win = win; p.nen = ne; p.nw = nw; p.nd = nd;
    return p;
  endfunction

  function automatic longint pmax(prm_t p);
    return (p.per < 2) ? 2 : p.per;
  endfunction

  // Expected {sync, pulse, inhib} at counter value t, straight from the timing rules.
  function automatic logic [2:0] lvl(longint t, prm_t p);
    longint P, d, s, e, last;
    bit pul, blk, syn, inh;
    P = pmax(p);
    if (p.n == 0) return {t < p.p1, 1'b1, 1'b0};
    d = 2 * p.dl + p.p2;
    pul = p.pump && (t < p.p1);
    blk = 1'b0;
    for (longint k = 0; k < p.n; k++) begin
      s = p.p1 + p.dl + k * d;
      e = s + p.p2 + p.dl;
      if (t >= s && t < s + p.p2) pul = 1'b1;
      if (t >= e - p.pre && t < e - p.pre + p.win) blk = 1'b1;
    end
    last = p.p1 + p.dl + (p.n - 1) * d + p.p2;
    syn = (t < last);
    if (p.nen && t >= P - p.nd - p.nw && t < P - p.nd) pul = 1'b1;
    inh = p.ben && !blk;
    return {syn, pul, inh};
  endfunction

  function automatic prm_t rand_prm();
    prm_t p;
    longint e0;
    p.per  = $urandom_range(20, 400);
    p.n    = $urandom_range(0, 5);
    p.p1   = $urandom_range(0, 40);
    p.dl   = $urandom_range(1, 40);
    p.p2   = $urandom_range(1, 20);
    e0     = p.p1 + 2 * p.dl + p.p2;
    p.pre  = $urandom_range(0, 32'(e0 - 1));
    p.win  = $urandom_range(0, 60);
    p.pump = 1'($urandom_range(0, 1));
    p.ben  = 1'($urandom_range(0, 1));
    p.nen  = 1'($urandom_range(0, 1));
    p.nw   = $urandom_range(0, 50);
    p.nd   = $urandom_range(0, 300);
    return p;
  endfunction

  task automatic drive(prm_t p);
    per = CW'(p.per); p1wid = TW'(p.p1); del = TW'(p.dl); p2wid = TW'(p.p2);
    npi = NW'(p.n); pump = p.pump; blk_en = p.ben; blk_pre = TW'(p.pre);
    blk_win = TW'(p.win); nut_en = p.nen; nut_w = TW'(p.nw); nut_d = TW'(p.nd);
  endtask

  // One clock of stimulus: drive pins, predict the registered response, advance the model.
  task automatic step(input bit do_rst, input bit do_ld, input prm_t p);
    exp_t e;
    bit   wrap;
    @(negedge clk);
    reset = do_rst;
    load  = do_ld;
    if (do_ld) drive(p);
    else begin
      per = CW'($urandom); p1wid = TW'($urandom); del = TW'($urandom); p2wid = TW'($urandom);
      npi = NW'($urandom); pump = 1'($urandom); blk_en = 1'($urandom); blk_pre = TW'($urandom);
      blk_win = TW'($urandom); nut_en = 1'($urandom); nut_w = TW'($urandom); nut_d = TW'($urandom);
    end
    if (do_rst) begin
      e.v = '0; e.t = -1;
      m_t = 0; m_act = dflt; m_stg = dflt; m_pend = 1'b0;
    end else begin
      wrap = (m_t == pmax(m_act) - 1);
      e.v = {lvl(m_t, m_act), m_t == 0, wrap && (do_ld || m_pend)};
      e.t = m_t;
      if (wrap) begin
        if (do_ld) m_act = p;
        else if (m_pend) m_act = m_stg;
        m_pend = 1'b0;
        m_t = 0;
      end else begin
        if (do_ld) begin
          m_stg = p;
          m_pend = 1'b1;
        end
        m_t++;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, dflt);
  endtask

  task automatic wait_applied();
    for (int i = 0; i < 70000 && m_pend; i++) step(1'b0, 1'b0, dflt);
    checks++;
    if (m_pend) begin
      errors++;
      $display("FAIL wait_applied expired with a load still pending");
    end
  endtask

  task automatic wait_t(longint tt);
    for (int i = 0; i < 70000 && m_t != tt; i++) step(1'b0, 1'b0, dflt);
    checks++;
    if (m_t != tt) begin
      errors++;
      $display("FAIL wait_t expired waiting for t=%0d (model t=%0d)", tt, m_t);
    end
  endtask

  // Monitor: every registered output word is compared with the oldest prediction.
  always begin
    exp_t e;
    logic [4:0] got;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {sync, pulse, inhib, frame, load_ack};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL outputs t=%0d sync/pulse/inhib/frame/ack got=%b exp=%b", e.t, got, e.v);
      end
    end
  end

  initial begin
    prm_t cpmg, cwm, nut, clmp, rp;
    dflt = mk(65536, 30, 200, 30, 1, 1, 1, 50, 100, 0, 0, 0);
    cpmg = mk(2000, 10, 50, 20, 3, 1, 1, 10, 30, 0, 0, 0);
    cwm  = mk(2000, 10, 50, 20, 0, 1, 1, 10, 30, 0, 0, 0);
    nut  = mk(1000, 30, 200, 30, 1, 1, 1, 50, 100, 1, 40, 100);
    clmp = mk(1, 30, 200, 30, 1, 1, 1, 5000, 100, 0, 0, 0);
    m_act = dflt; m_stg = dflt; m_pend = 1'b0; m_t = 0;
    reset = 1'b1; load = 1'b0;
    drive(dflt);

    repeat (3) step(1'b1, 1'b0, dflt);

    @(posedge clk);
    #2;
    checks++;
    if ({sync, pulse, inhib, frame, load_ack} !== 5'b00000) begin
      errors++;
      $display("FAIL reset state outputs got=%b exp=00000",
               {sync, pulse, inhib, frame, load_ack});
    end

    // Defaults period, with the CPMG set staged early and applied at the 65536 wrap.
    run(1000);
    step(1'b0, 1'b1, cpmg);
    wait_applied();
    run(4000);

    // Mid-period switch to CW mode.
    wait_t(700);
    step(1'b0, 1'b1, cwm);
    wait_applied();
    run(2500);

    // Nutation pulse at the end of each period.
    step(1'b0, 1'b1, nut);
    wait_applied();
    run(2100);

    // Load coinciding with the wrap cycle bypasses staging.
    wait_t(pmax(m_act) - 1);
    step(1'b0, 1'b1, rand_prm());
    run(300);

    // Degenerate period and block pre-time.
    step(1'b0, 1'b1, clmp);
    wait_applied();
    run(20);

    // Random parameter sets loaded at random points, sometimes twice per period.
    for (int i = 0; i < 10; i++) begin
      run($urandom_range(0, 300));
      step(1'b0, 1'b1, rand_prm());
      if ($urandom_range(0, 1) == 1) begin
        run($urandom_range(0, 10));
        step(1'b0, 1'b1, rand_prm());
      end
      wait_applied();
      run($urandom_range(200, 600));
    end

    // Reset mid-CPMG period with a load pending.
    step(1'b0, 1'b1, cpmg);
    wait_applied();
    wait_t(140);
    rp = rand_prm();
    step(1'b0, 1'b1, rp);
    wait_t(150);
    step(1'b1, 1'b0, dflt);
    run(100);

    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
